// File: rtl/vcc_wr_initiator.sv
// VALU-side VCC write front end: eight per-source FIFOs, round-robin arbitration,
// and one registered write per cycle, stalled by a same-wavefront SALU VCC write.
module vcc_wr_initiator #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            src_wr_en,
  input  logic [47:0]           src_wr_wfid,
  input  logic [8*DATA_W-1:0]   src_wr_data,
  output logic [7:0]            src_ready,
  input  logic                  salu_wr_vcc_en,
  input  logic [5:0]            salu_wr_wfid,
  output logic                  vcc_wr_en,
  output logic [5:0]            vcc_wr_wfid,
  output logic [DATA_W-1:0]     vcc_wr_data,
  output logic [7:0]            pending,
  output logic [7:0]            overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [5:0]        r_mem_wfid [8][DEPTH];
  logic [DATA_W-1:0] r_mem_data [8][DEPTH];
  logic [AW-1:0]     r_wptr [8];
  logic [AW-1:0]     r_rptr [8];
  logic [CW-1:0]     r_cnt  [8];
  logic [2:0]        r_rr_ptr;
  logic [7:0]        r_ovf;
  logic              r_vld_p1;
  logic [5:0]        r_wfid_p1;
  logic [DATA_W-1:0] r_data_p1;

  logic [7:0]        w_ready;
  logic [7:0]        w_nonempty;
  logic [7:0]        w_push;
  logic [7:0]        w_pop;
  logic              w_any;
  logic [2:0]        w_cand;
  logic [5:0]        w_head_wfid;
  logic [DATA_W-1:0] w_head_data;
  logic              w_hazard;
  logic              w_grant;

  always_comb begin
    w_ready    = '0;
    w_nonempty = '0;
    for (int i = 0; i < 8; i++) begin
      w_ready[i]    = (r_cnt[i] < CW'(DEPTH));
      w_nonempty[i] = (r_cnt[i] != '0);
    end
  end

  assign w_push = src_wr_en & w_ready;

  // Descending scan so the nonempty FIFO closest above rr_ptr is the last one written.
  always_comb begin
    w_any  = 1'b0;
    w_cand = '0;
    for (int k = 7; k >= 0; k--) begin
      if (w_nonempty[r_rr_ptr + 3'(k)]) begin
        w_any  = 1'b1;
        w_cand = r_rr_ptr + 3'(k);
      end
    end
  end

  assign w_head_wfid = r_mem_wfid[w_cand][r_rptr[w_cand]];
  assign w_head_data = r_mem_data[w_cand][r_rptr[w_cand]];
  assign w_hazard    = salu_wr_vcc_en && (salu_wr_wfid == w_head_wfid);
  assign w_grant     = w_any && !w_hazard;
  assign w_pop       = w_grant ? (8'b1 << w_cand) : 8'b0;

  // FIFO storage carries no reset; stale entries are never read while count is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (w_push[i]) begin
        r_mem_wfid[i][r_wptr[i]] <= src_wr_wfid[6*i +: 6];
        r_mem_data[i][r_wptr[i]] <= src_wr_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
      r_ovf <= r_ovf | (src_wr_en & ~w_ready);
    end
  end

  // Stage p1: registered write toward the VCC file and the issue notification
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_wfid_p1 <= '0;
      r_data_p1 <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_vld_p1 <= w_grant;
      if (w_grant) begin
        r_wfid_p1 <= w_head_wfid;
        r_data_p1 <= w_head_data;
        r_rr_ptr  <= w_cand + 3'd1;
      end
    end
  end

  assign src_ready    = w_ready;
  assign pending      = w_nonempty;
  assign overflow_err = r_ovf;
  assign vcc_wr_en    = r_vld_p1;
  assign vcc_wr_wfid  = r_wfid_p1;
  assign vcc_wr_data  = r_data_p1;

endmodule
